// File: rtl/decimal_key_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the decimal key arbiter path.
package decimal_kbd_pkg;

  localparam int N_KEYS = 10;
  localparam int BCD_W  = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_OFFER    = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Add two digits 0..9 modulo 10; a single subtract suffices because the sum is at most 18.
  function automatic logic [3:0] mod10_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

endpackage

// File: rtl/decimal_key_arbiter_if.sv
// BCD code handshake between the key arbiter (master) and a BCD consumer (slave).
interface decimal_key_arbiter_if;
  import decimal_kbd_pkg::*;

  logic [BCD_W-1:0] code;
  logic             code_valid;
  logic             code_ready;
  logic             multi;

  modport master (output code, output code_valid, output multi, input code_ready);
  modport slave  (input code, input code_valid, input multi, output code_ready);
endinterface

// File: rtl/decimal_key_arbiter_encoder.sv
// Combinational round-robin picker: first set request at or after ptr, plus a multi-key flag.
module bcd_rr_encoder
  import decimal_kbd_pkg::*;
(
  input  logic [N_KEYS-1:0] req,
  input  logic [3:0]        ptr,
  output logic [BCD_W-1:0]  idx,
  output logic              multi
);

  logic [N_KEYS-1:0] rot;
  logic [3:0]        pos;
  logic              found;
  logic [3:0]        ones;

  // Rotate so that bit 0 of rot corresponds to request line ptr.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_KEYS; i++) rot[i] = req[mod10_add(4'(i), ptr)];
  end

  // Lowest set bit of the rotated vector, mapped back to the original line number.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 4'(i);
      end
    end
    idx = mod10_add(pos, ptr);
  end

  // More than one request line set.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N_KEYS; i++) ones = ones + {3'b000, req[i]};
    multi = (ones > 4'd1);
  end

endmodule

// File: rtl/decimal_key_arbiter.sv
// Debounces ten key lines, grants one key per press round-robin, offers it as BCD via valid/ready.
module decimal_key_arbiter
  import decimal_kbd_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic              busy,
  decimal_key_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [N_KEYS-1:0] snap;
  logic [3:0]        ptr;
  logic [BCD_W-1:0]  code_r;
  logic              code_valid_r;
  logic              multi_r;
  logic [BCD_W-1:0]  grant_idx;
  logic              grant_multi;

  bcd_rr_encoder u_enc (
    .req   (snap),
    .ptr   (ptr),
    .idx   (grant_idx),
    .multi (grant_multi)
  );

  assign busy           = (state != ST_IDLE);
  assign bus.code       = code_r;
  assign bus.code_valid = code_valid_r;
  assign bus.multi      = multi_r;

  // Snapshot register: reloaded on every new or changed press, no reset needed.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE && key != '0) ||
        (state == ST_DEBOUNCE && key != '0 && key != snap))
      snap <= key;
  end

  // Press/release FSM with saturating debounce counter and registered BCD offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ptr          <= '0;
      code_r       <= '0;
      code_valid_r <= 1'b0;
      multi_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key != '0) begin
            cnt   <= CNT_W'(1);
            state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (key == '0) begin
            state <= ST_IDLE;
          end else if (key != snap) begin
            cnt <= CNT_W'(1);
          end else if (cnt < DEB_MAX) begin
            cnt <= cnt + 1'b1;
          end else begin
            code_r       <= grant_idx;
            code_valid_r <= 1'b1;
            multi_r      <= grant_multi;
            ptr          <= (grant_idx == 4'd9) ? 4'd0 : grant_idx + 4'd1;
            state        <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (bus.code_ready) begin
            code_valid_r <= 1'b0;
            cnt          <= '0;
            state        <= ST_RELEASE;
          end
        end
        default: begin
          if (key != '0) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == DEB_MAX) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_key_arbiter.sv
// Directed scoreboard bench for decimal_key_arbiter (DEB_CYCLES=4).
module tb_decimal_key_arbiter;

  typedef struct packed {
    logic [3:0] code;
    logic       multi;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] key;
  logic       busy;
  int         errors;
  int         checks;
  exp_t       sb[$];

  decimal_key_arbiter_if bus ();

  decimal_key_arbiter #(.DEB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every accepted code must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.code_valid === 1'b1 && bus.code_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got code=%0d multi=%0d with nothing expected",
                 bus.code, bus.multi);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.code !== e.code || bus.multi !== e.multi) begin
          errors++;
          $display("FAIL sb_code: got code=%0d multi=%0d expected code=%0d multi=%0d",
                   bus.code, bus.multi, e.code, e.multi);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int maxc, output int n);
    n = 0;
    while (bus.code_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (bus.code_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: code_valid=%0d after %0d cycles, required 1", name,
               bus.code_valid, n);
    end
  endtask

  // One full press: push expectation, hold key until offered, then release to IDLE.
  task automatic press(input string name, input logic [9:0] k, input logic [3:0] c,
                       input logic m);
    int n;
    exp_t e;
    e.code  = c;
    e.multi = m;
    sb.push_back(e);
    key = k;
    wait_valid(name, 20, n);
    repeat (3) tick();
    key = '0;
    repeat (6) tick();
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    int vcnt;
    errors = 0;
    checks = 0;
    key = '0;
    bus.code_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(bus.code_valid), 0);
    chk("rst_code", int'(bus.code), 0);
    chk("rst_multi", int'(bus.multi), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single key, latency, one-shot, release timing
    sb.push_back('{code: 4'd7, multi: 1'b0});
    key = 10'h080;
    wait_valid("t1", 20, n);
    chk("t1_latency", n, 5);
    vcnt = 1;
    repeat (7) begin
      tick();
      if (bus.code_valid === 1'b1) vcnt++;
    end
    chk("t1_one_shot", vcnt, 1);
    chk("t1_busy_held", int'(busy), 1);
    key = '0;
    repeat (3) tick();
    chk("t1_busy_3", int'(busy), 1);
    tick();
    chk("t1_busy_4", int'(busy), 0);

    // 2: bouncing key never yields a code
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      key = ((i / 2) % 2 == 0) ? 10'h080 : 10'h000;
      tick();
      if (bus.code_valid === 1'b1) vcnt++;
    end
    key = '0;
    repeat (3) tick();
    chk("t2_bounce", vcnt, 0);

    // 3: round-robin from ptr=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    press("t3a", 10'h220, 4'd5, 1'b1);
    press("t3b", 10'h220, 4'd9, 1'b1);
    press("t3c", 10'h220, 4'd5, 1'b1);

    // 4: wrap-around after a grant of 9
    press("t4a", 10'h220, 4'd9, 1'b1);
    press("t4b", 10'h201, 4'd0, 1'b1);
    press("t4c", 10'h201, 4'd9, 1'b1);

    // 5: backpressure holds the offer stable
    bus.code_ready = 1'b0;
    sb.push_back('{code: 4'd4, multi: 1'b0});
    key = 10'h010;
    wait_valid("t5", 20, n);
    vcnt = 0;
    repeat (6) begin
      tick();
      if (bus.code_valid === 1'b1 && bus.code === 4'd4 && bus.multi === 1'b0) vcnt++;
    end
    chk("t5_stable", vcnt, 6);
    bus.code_ready = 1'b1;
    tick();
    chk("t5_drop", int'(bus.code_valid), 0);
    chk("t5_code_kept", int'(bus.code), 4);
    key = '0;
    repeat (6) tick();

    // 6: asynchronous reset during OFFER
    bus.code_ready = 1'b0;
    key = 10'h008;
    wait_valid("t6", 20, n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(bus.code_valid), 0);
    chk("t6_code", int'(bus.code), 0);
    chk("t6_busy", int'(busy), 0);
    key = '0;
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    bus.code_ready = 1'b1;
    press("t6_ptr", 10'h201, 4'd0, 1'b1);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
